// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state type and defaults for the load/store unit.
package lsu_pkg;

  localparam int MEM_WORDS_DEFAULT = 256;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  // Stores only have signed-less B/H/W forms; loads add the unsigned variants.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    logic legal;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~we;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte/half lane extraction with extension for loads, and lane merge for stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfwords select on offset[1] only; offset[0] is either trapped upstream or ignored.
  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_data = {24'h0, byte_lane};
      F3_HU:   load_data = {16'h0, half_lane};
      default: load_data = word;
    endcase

    store_word = word;
    case (funct3)
      F3_B: store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: request/response handshakes, error checks and a read-modify-write FSM.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned halfword/word accesses as errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          MEM_WORDS   = MEM_WORDS_DEFAULT,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output lsu_state_e  state
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
  // the sender holds its payload stable while valid is high and ready is low.

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  lsu_state_e  state_next;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_fire;
  logic        resp_fire;
  logic        misaligned;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_fire  = req_valid & req_ready;
  assign resp_fire = resp_valid & resp_ready;

  always_comb begin
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3)
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W:        misaligned = |req_addr[1:0];
      default:     misaligned = 1'b0;
    endcase
`endif
  end

  assign req_err = (req_addr >= ADDR_LIMIT) | ~funct3_legal(req_we, req_funct3) | misaligned;

  lsu_lane_align u_lane_align (
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .word       (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_fire) state_next = req_err ? RESP : EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory signals are decoded from state so an async reset drops mem_write at once.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 32'h0;
    mem_write_data = 32'h0;
    case (state)
      IDLE: req_ready = reset;
      EXEC: begin
        mem_address    = {addr_q[31:2], 2'b00};
        mem_write      = we_q;
        mem_write_data = we_q ? store_word : 32'h0;
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      resp_rdata <= RESET_RDATA;
      resp_err   <= 1'b0;
    end else begin
      if (req_fire) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        resp_err <= req_err;
        if (req_err) resp_rdata <= RESET_RDATA;
      end
      if (state == EXEC) resp_rdata <= we_q ? 32'h0 : load_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit with a byte-level reference memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam logic [31:0] RESET_RDATA = 32'h0000_0000;
  localparam int          MEM_WORDS   = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  lsu_state_e  state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem     [MEM_WORDS] = '{default: 32'h0};
  logic [31:0] ref_mem [MEM_WORDS] = '{default: 32'h0};

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .RESET_RDATA(RESET_RDATA)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .state          (state)
  );

  // Data memory: combinational read, word write on the rising edge.
  assign mem_read_data = mem[mem_address[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access described as size/offset/sign over a byte view of ref_mem.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int size;
    bit is_signed;
    bit legal;
    int off;
    int idx;
    logic [31:0] word;
    logic [31:0] val;
    legal = 1; is_signed = 0; size = 4;
    case (f3)
      3'd0: begin size = 1; is_signed = 1; end
      3'd1: begin size = 2; is_signed = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: legal = 0;
    endcase
    err = !legal || (addr >= 32'(4 * MEM_WORDS));
`ifdef LSU_MISALIGN_TRAP_EN
    if (!err && (addr % size) != 0) err = 1;
`endif
    rdata = RESET_RDATA;
    if (err) return;
    rdata = 32'h0;
    idx  = int'(addr / 4);
    off  = int'(((addr % 4) / size) * size);
    word = ref_mem[idx];
    if (we) begin
      for (int b = 0; b < size; b++) word[8*(off+b) +: 8] = wdata[8*b +: 8];
      ref_mem[idx] = word;
    end else begin
      val = 32'h0;
      for (int b = 0; b < size; b++) val[8*b +: 8] = word[8*(off+b) +: 8];
      if (is_signed && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
      rdata = val;
    end
  endtask

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          waited;
    logic        write_seen;
    model_access(we, f3, addr, wdata, exp_rdata, exp_err);
    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    write_seen = mem_write;
    if (!exp_err) begin
      check("exec_state", 32'(state), 32'(EXEC));
      check("exec_mem_address", mem_address, {addr[31:2], 2'b00});
      check("exec_mem_write", 32'(mem_write), 32'(we));
    end
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      write_seen = write_seen | mem_write;
    end
    check("resp_latency", 32'(lat), exp_err ? 32'd1 : 32'd2);
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("mem_write_seen", 32'(write_seen), 32'(we && !exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_rdata);
      check("hold_err", 32'(resp_err), 32'(exp_err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("resp_done", 32'(resp_valid), 32'd0);
    if (addr < 32'(4 * MEM_WORDS))
      check("mem_word", mem[addr[9:2]], ref_mem[addr[9:2]]);
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, RESET_RDATA);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_write_data", mem_write_data, 32'h0);
    check("rst_state", 32'(state), 32'(IDLE));
    reset = 1'b1;

    // Word write then read back.
    do_op(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 0);
    do_op(1'b0, F3_W, 32'h10, 32'h0, 0);

    // Byte store merge and signed/unsigned byte loads.
    do_op(1'b1, F3_W, 32'h10, 32'h1122_3344, 0);
    do_op(1'b1, F3_B, 32'h12, 32'h0000_00AA, 0);
    do_op(1'b0, F3_W, 32'h10, 32'h0, 0);
    do_op(1'b0, F3_B, 32'h12, 32'h0, 0);
    do_op(1'b0, F3_BU, 32'h12, 32'h0, 0);

    // Upper-half store and halfword loads.
    do_op(1'b1, F3_W, 32'h14, 32'h5566_7788, 0);
    do_op(1'b1, F3_H, 32'h16, 32'h0000_8001, 0);
    do_op(1'b0, F3_H, 32'h16, 32'h0, 0);
    do_op(1'b0, F3_HU, 32'h16, 32'h0, 0);
    do_op(1'b0, F3_W, 32'h14, 32'h0, 0);

    // Error cases: out of range, illegal funct3, misaligned word store.
    do_op(1'b0, F3_W, 32'h400, 32'h0, 0);
    do_op(1'b1, F3_W, 32'hFFFF_FFF0, 32'h1234_5678, 0);
    do_op(1'b0, 3'b011, 32'h10, 32'h0, 0);
    do_op(1'b1, F3_BU, 32'h10, 32'h0, 0);
    do_op(1'b1, F3_W, 32'h13, 32'h9ABC_DEF0, 0);
    do_op(1'b0, F3_W, 32'h10, 32'h0, 0);
    do_op(1'b0, F3_H, 32'h17, 32'h0, 0);

    // Back-pressure on the response.
    do_op(1'b0, F3_W, 32'h10, 32'h0, 5);

    // Reset during the write cycle of a store abandons it.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h20;
    req_wdata  = 32'hCAFE_F00D;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_exec_write_before", 32'(mem_write), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_exec_mem_write", 32'(mem_write), 32'd0);
    check("rst_exec_req_ready", 32'(req_ready), 32'd0);
    check("rst_exec_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_exec_resp_err", 32'(resp_err), 32'd0);
    check("rst_exec_rdata", resp_rdata, RESET_RDATA);
    check("rst_exec_mem_address", mem_address, 32'h0);
    check("rst_exec_mem_wdata", mem_write_data, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_exec_mem_untouched", mem[8], ref_mem[8]);
    reset = 1'b1;
    do_op(1'b0, F3_W, 32'h20, 32'h0, 0);
    do_op(1'b1, F3_H, 32'h22, 32'h0000_BEEF, 1);
    do_op(1'b0, F3_W, 32'h20, 32'h0, 0);

    // Randomized mix over a small window so stores and loads collide.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 15))
                                       : 32'($urandom_range(0, 63));
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-addressed data memory (256 x 32, word write enable, combinational read).
- Accepts RV32I load/store requests over a valid/ready handshake.
- Byte/halfword stores are done as read-modify-write of the containing word; loads are returned with byte/half extraction and sign/zero extension.
- Responses return over a second valid/ready channel; alignment, range and funct3 errors are flagged.

Parameters:
MEM_WORDS, 256, data memory depth in 32-bit words; byte addresses >= 4*MEM_WORDS are out of range.
RESET_RDATA, 32'h0000_0000, value of resp_rdata after reset and on any error response.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I width/sign code.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned.
resp_valid  output  1  response present.
resp_ready  input  1  consumer accepts response.
resp_rdata  output  32  load result; 0 for stores.
resp_err  output  1  illegal funct3, misaligned (feature on) or out of range.
mem_write  output  1  data memory write enable.
mem_address  output  32  word-aligned byte address to memory.
mem_write_data  output  32  merged word to memory.
mem_read_data  input  32  combinational memory read word.

Behaviour:
- Reset (reset low, async): state=IDLE, req_ready=0 while asserted, resp_valid=0, resp_err=0, resp_rdata=RESET_RDATA, mem_write=0, mem_address=0, mem_write_data=0.
- Reset asserted in EXEC or RESP: the access is abandoned; mem_write drops immediately; no partial write beyond a completed clock edge.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, latch we/funct3/addr/wdata and evaluate the error condition.
  - Error: go straight to RESP with resp_err=1 and rdata=RESET_RDATA; memory is never written.
  - Otherwise go to EXEC.
- EXEC, exactly one cycle: mem_address={addr[31:2],2'b00}.
  - Load: extract lane (byte = addr[1:0], half = addr[1]), extend, register into resp_rdata.
  - Store: mem_write=1; mem_write_data = mem_read_data with the selected lane(s) replaced by wdata[7:0] / wdata[15:0] / full word.
  - Go to RESP.
- RESP: resp_valid=1, outputs stable until resp_ready; on the handshake go to IDLE. No request is accepted in the same cycle (req_ready=0 outside IDLE).
- Latency: request accepted at edge N gives resp_valid high after edge N+2 (error path: after N+1). Minimum 3 cycles per op with resp_ready tied high.
- mem_write is high only in EXEC for a non-error store.
- funct3 loads: 000 LB sext, 001 LH sext, 010 LW, 100 LBU zext, 101 LHU zext. Stores: 000 SB, 001 SH, 010 SW. Any other code sets err.
- Range: addr >= 4*MEM_WORDS sets err (checked before alignment).

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, or word with addr[1:0]!=0, sets err; no memory access.
- Undefined: no misalignment error. Half uses addr[1] and ignores addr[0]; word ignores addr[1:0].

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state typedef (IDLE/EXEC/RESP), MEM_WORDS default.
- Sub-module lsu_lane_align: combinational extract/extend and store merge, given funct3, addr[1:0], word and wdata.
- Top keeps the FSM, error checks and handshake registers.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> word 4 = 0xDEADBEEF; rdata=0xDEADBEEF, err=0; resp_valid two cycles after acceptance.
- Preload word 4 = 0x11223344, SB addr 0x12 data 0xAA -> word 4 = 0x11AA3344. Then LB 0x12 -> 0xFFFFFFAA; LBU 0x12 -> 0x000000AA.
- SH addr 0x16 data 0x8001 -> upper half of word 5 replaced. Then LH 0x16 -> 0xFFFF8001; LHU 0x16 -> 0x00008001.
- LW addr 0x400 (out of range, MEM_WORDS=256) -> err=1, rdata=0, mem_write never high. Also funct3=011 load -> err=1. Also SW addr 0x13 -> err=1 with the feature on; with it off, word 4 is written.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid, rdata and err stable; req_ready=0 throughout; completes on resp_ready=1.
- Assert reset during EXEC of an SW -> mem_write falls immediately; outputs take reset values; the next request after release completes normally.
